// File: rtl/cmp_seq_slice.sv
// Sequential slice-wise magnitude comparator with cascade inputs.
// One SLICE-bit slice per cycle, MSB slice first, early exit on difference.
module cmp_seq_slice #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8,
  localparam int NSLICE = WIDTH / SLICE,
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_mode_i,
  input  logic             fi_big_i,
  input  logic             fi_equal_i,
  input  logic             fi_small_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             fo_big_o,
  output logic             fo_equal_o,
  output logic             fo_small_o,
  output logic [IDXW-1:0]  out_idx_o
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             casc_q;
  logic             cbig_q;
  logic [IDXW-1:0]  idx_q;
  logic             out_valid_q;
  logic             big_q;
  logic             eq_q;
  logic             small_q;
  logic [IDXW-1:0]  oidx_q;

  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic             s_gt;
  logic             s_lt;
  logic             s_ne;
  logic             finish;

  // fi_small is redundant with fi_big once fi_equal is low
  logic             unused_fi_small;
  assign unused_fi_small = fi_small_i;

  // operands shift left each step, so the live slice is always on top
  assign sa     = a_q[WIDTH-1 -: SLICE];
  assign sb     = b_q[WIDTH-1 -: SLICE];
  assign s_gt   = sa > sb;
  assign s_lt   = sa < sb;
  assign s_ne   = s_gt | s_lt;
  assign finish = !casc_q || s_ne || (idx_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      casc_q      <= 1'b0;
      cbig_q      <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      big_q       <= 1'b0;
      eq_q        <= 1'b0;
      small_q     <= 1'b0;
      oidx_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            // signed order == unsigned order after flipping both sign bits
            a_q     <= a_i ^ (signed_mode_i ? MSB : '0);
            b_q     <= b_i ^ (signed_mode_i ? MSB : '0);
            casc_q  <= fi_equal_i;
            cbig_q  <= fi_big_i;
            idx_q   <= IDX_TOP;
            state_q <= CMP;
          end
        end
        CMP: begin
          if (finish) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            big_q       <= casc_q ? s_gt : cbig_q;
            small_q     <= casc_q ? s_lt : !cbig_q;
            eq_q        <= casc_q && !s_ne;
            oidx_q      <= (casc_q && s_ne) ? idx_q : '0;
          end else begin
            idx_q <= idx_q - IDXW'(1);
            a_q   <= a_q << SLICE;
            b_q   <= b_q << SLICE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = out_valid_q;
  assign fo_big_o    = big_q;
  assign fo_equal_o  = eq_q;
  assign fo_small_o  = small_q;
  assign out_idx_o   = oidx_q;

endmodule

// File: tb/tb_cmp_seq_slice.sv
// Directed bench for cmp_seq_slice (WIDTH=64, SLICE=8).
// Table of vectors plus hand sequences for stall and mid-compare reset.
module tb_cmp_seq_slice;

  localparam int W = 64;
  localparam int S = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sgn;
  logic         fi_big;
  logic         fi_equal;
  logic         fi_small;
  logic         out_valid;
  logic         out_ready;
  logic         fo_big;
  logic         fo_equal;
  logic         fo_small;
  logic [2:0]   out_idx;

  int checks = 0;
  int errors = 0;

  cmp_seq_slice #(.WIDTH(W), .SLICE(S)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .a_i           (a),
    .b_i           (b),
    .signed_mode_i (sgn),
    .fi_big_i      (fi_big),
    .fi_equal_i    (fi_equal),
    .fi_small_i    (fi_small),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .fo_big_o      (fo_big),
    .fo_equal_o    (fo_equal),
    .fo_small_o    (fo_small),
    .out_idx_o     (out_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic         fbig;
    logic         feq;
    logic         fsmall;
    logic         ebig;
    logic         eeq;
    logic         esmall;
    int           eidx;
    int           lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic accept(input vec_t v);
    a        = v.a;
    b        = v.b;
    sgn      = v.sgn;
    fi_big   = v.fbig;
    fi_equal = v.feq;
    fi_small = v.fsmall;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    sgn      = ~sgn;
    fi_equal = ~fi_equal;
  endtask

  // returns number of edges after accept until out_valid seen, 0 on timeout
  task automatic wait_valid(output int n);
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int n;
    chk($sformatf("v%0d_in_ready", id), longint'(in_ready), 1);
    accept(v);
    wait_valid(n);
    chk($sformatf("v%0d_latency", id), n, v.lat - 1);
    chk($sformatf("v%0d_big", id), longint'(fo_big), longint'(v.ebig));
    chk($sformatf("v%0d_equal", id), longint'(fo_equal), longint'(v.eeq));
    chk($sformatf("v%0d_small", id), longint'(fo_small), longint'(v.esmall));
    chk($sformatf("v%0d_idx", id), longint'(out_idx), v.eidx);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk($sformatf("v%0d_pop_ready", id), longint'(in_ready), 1);
    chk($sformatf("v%0d_pop_valid", id), longint'(out_valid), 0);
  endtask

  initial begin
    int n;
    int seen;

    vecs[0]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
                 0, 0, 1, 0, 1, 0, 0, 7, 2};
    vecs[1]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
                 1, 0, 1, 0, 0, 0, 1, 7, 2};
    vecs[2]  = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,
                 0, 0, 1, 0, 0, 1, 0, 0, 9};
    vecs[3]  = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDF0,
                 0, 0, 1, 0, 0, 0, 1, 0, 9};
    vecs[4]  = '{64'h0, 64'h0, 0, 1, 0, 0, 1, 0, 0, 0, 2};
    vecs[5]  = '{64'h0, 64'h0, 0, 0, 0, 1, 0, 0, 1, 0, 2};
    vecs[6]  = '{64'h0000_0000_0500_0000, 64'h0000_0000_0400_0000,
                 0, 0, 1, 0, 1, 0, 0, 3, 6};
    vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
                 1, 0, 1, 0, 1, 0, 0, 0, 9};
    vecs[8]  = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF,
                 1, 0, 1, 0, 1, 0, 0, 7, 2};
    vecs[9]  = '{64'h1234, 64'h1234, 0, 0, 0, 0, 0, 0, 1, 0, 2};
    vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                 0, 0, 1, 1, 1, 0, 0, 7, 2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sgn       = 1'b0;
    fi_big    = 1'b0;
    fi_equal  = 1'b1;
    fi_small  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_fo", longint'({fo_big, fo_equal, fo_small}), 0);
    chk("rst_idx", longint'(out_idx), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // result held while consumer stalls and new requests knock
    accept(vecs[0]);
    wait_valid(n);
    chk("stall_latency", n, 1);
    in_valid = 1'b1;
    a        = 64'h1;
    b        = 64'h2;
    fi_equal = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_valid", c), longint'(out_valid), 1);
      chk($sformatf("stall%0d_fo", c),
          longint'({fo_big, fo_equal, fo_small}), 3'b100);
      chk($sformatf("stall%0d_idx", c), longint'(out_idx), 7);
      chk($sformatf("stall%0d_ready", c), longint'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("stall_pop_ready", longint'(in_ready), 1);
    chk("stall_pop_valid", longint'(out_valid), 0);
    chk("stall_hold_fo", longint'({fo_big, fo_equal, fo_small}), 3'b100);
    chk("stall_hold_idx", longint'(out_idx), 7);

    // reset in the middle of an all-equal compare
    accept(vecs[2]);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_fo", longint'({fo_big, fo_equal, fo_small}), 0);
    chk("mid_rst_idx", longint'(out_idx), 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", longint'(in_ready), 1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("mid_rst_stale", seen, 0);
    run_vec(vecs[6], 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
